poly1305_sequencer: RTL
=======================

# poly1305_sequencer

Streaming controller in front of `poly1305_serial_encoder`. It accepts a one-time key and a stream of up to-16-byte message blocks over valid/ready handshakes. It issues one `start` pulse per block and holds the encoder inputs stable for the encoder's fixed per-block latency. It then captures the 128-bit tag and presents it on a valid/ready output. One message is in flight at a time; the next key is accepted only after the tag has been taken.

## Interface
- `BLOCK_CYCLES`, default 8: cycles from an encoder `start` pulse until the encoder can take the next block (≥2).
- `TAG_CYCLES`, default 8: cycles from the final block's `start` pulse until the encoder `tag` is valid (≥2).
- `clock`  in  1  sole clock; all logic on rising edge.
- `clear`  in  1  synchronous, active-high reset.
- `key_valid` / `key_ready`  in / out  1 / 1  key handshake.
- `key`  in  256  {s, r} one-time key, sampled on key handshake.
- `in_valid` / `in_ready`  in / out  1 / 1  block handshake.
- `in_data`  in  128  message block, little-endian, bytes beyond the count are don't-care.
- `in_bytes_minus_one`  in  4  valid bytes − 1 (0..15).
- `in_last`  in  1  final block of message.
- `tag_valid` / `tag_ready`  out / in  1 / 1  tag handshake.
- `tag`  out  128  registered Poly1305 tag.
- `err`  out  1  sticky: non-last block with `in_bytes_minus_one != 15`; cleared only by `clear`.
- `enc_clear`, `enc_start`  out  1  to encoder.
- `enc_key`  out  256  to encoder.
- `enc_round_input`  out  128  to encoder.
- `enc_bytes_minus_one`  out  4  to encoder.
- `enc_tag`  in  128  from encoder.

## Operation
- FSM states: IDLE, ACCEPT, RUN, FINAL, DONE.
- IDLE: `key_ready=1`. On key handshake:
  - register `key` into `enc_key`;
  - pulse `enc_clear` for 1 cycle (next cycle);
  - go to ACCEPT.
- ACCEPT: `in_ready=1`. On block handshake:
  - register data, count and last into `enc_*`;
  - assert `enc_start` for exactly the next cycle;
  - load the counter with `BLOCK_CYCLES-1` (or `TAG_CYCLES-1` if last);
  - go to RUN (or FINAL if last).
- RUN: decrement the counter; at 0 return to ACCEPT. `in_ready=0` throughout.
- FINAL: decrement the counter; at 0 capture `enc_tag` into `tag` and go to DONE.
- DONE: `tag_valid=1`, with `tag` stable. On `tag_ready` go to IDLE and drop `tag_valid` the next cycle.
- `enc_key`, `enc_round_input` and `enc_bytes_minus_one` are held unchanged from the start pulse until the next accepted block or key.
- Short non-last block: set `err`, but process it as given; the sequencer does not drop it.
- Zero-length messages are unsupported; every message has ≥1 block, with `in_last` on the final block.
- `in_valid` in states other than ACCEPT is ignored (`in_ready=0`). `key_valid` outside IDLE is ignored.
- Counter width: `$clog2(max(BLOCK_CYCLES,TAG_CYCLES))`, with no wrap; decrement only when nonzero.

## Timing
- Reset values:
  - state IDLE;
  - `key_ready=0` during `clear`, then 1 the cycle after `clear` deasserts;
  - `in_ready=0`, `tag_valid=0`, `err=0`, `enc_start=0`;
  - `enc_clear=1` while `clear` is high (`enc_clear = clear | pulse`);
  - `tag`, `enc_key`, `enc_round_input`, `enc_bytes_minus_one` = 0.
- Per block:
  - handshake at cycle T;
  - `enc_start` high at T+1;
  - `in_ready` high again at T+`BLOCK_CYCLES`+1.
  - Block throughput: one per `BLOCK_CYCLES`+1 cycles with `in_valid` held high.
- Tag: last-block handshake at T; `tag_valid` at T+`TAG_CYCLES`+1.
- `clear` mid-message: abandon all state at the next edge. No tag is produced for that message.
- A key handshake and a pending `in_valid` cannot coincide: the states are exclusive.

## Structure
- Shared `poly1305_pkg`:
  - state enum;
  - `KEY_W=256`, `BLOCK_W=128`, `TAG_W=128`;
  - `FULL_BLOCK_BYTES_MINUS_ONE=4'd15`.
- Single flat module with no sub-modules.
- A separate wrapper instantiates `poly1305_sequencer` together with `poly1305_serial_encoder`. The bench uses that wrapper end-to-end and also runs the sequencer alone with a stub encoder.

## Test plan
- RFC 8439 §2.5.2 vector:
  - key r=85d6be7857556d337f4452fe42d506a8, s=0103808afb0db2fd4abff6af4149f51b;
  - message "Cryptographic Forum Research Group" sent as 3 blocks, `in_bytes_minus_one` 15, 15, 1;
  - required: `tag_valid` with `tag`=a8061dc1305136c6c22b8baf0c0127a9.
- Timing, `BLOCK_CYCLES`=8: continuous `in_valid` over 4 blocks gives `enc_start` pulses exactly 9 cycles apart, each 1 cycle wide.
- Backpressure: hold `tag_ready=0` for 20 cycles. Required: `tag` stable and `tag_valid` held throughout; `key_ready` rises the cycle after `tag_ready`.
- `clear` asserted in RUN after block 2 of 3:
  - next cycle: state IDLE, `enc_clear`=1, `tag_valid`=0;
  - a new full message afterwards gives the correct tag.
- Non-last block with `in_bytes_minus_one`=7: `err`=1 and stays 1 through the rest of the message; a subsequent message still completes.
- Single 1-byte message (`in_bytes_minus_one`=0, `in_last`=1): `tag_valid` at T+`TAG_CYCLES`+1, with `tag` equal to the reference-model value.

Source files
------------

// File: rtl/poly1305_pkg.sv
// Shared types and widths for the Poly1305 sequencer and its encoder wrapper.
package poly1305_pkg;

    localparam int unsigned KEY_W   = 256;
    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned TAG_W   = 128;

    localparam logic [3:0] FULL_BLOCK_BYTES_MINUS_ONE = 4'd15;

    typedef enum logic [2:0] {
        StIdle,
        StAccept,
        StRun,
        StFinal,
        StDone
    } seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/poly1305_sequencer.sv
// Key/block/tag handshake controller that paces a fixed-latency Poly1305 encoder,
// one message in flight at a time.
module poly1305_sequencer
    import poly1305_pkg::*;
#(
    parameter int unsigned BLOCK_CYCLES = 8,
    parameter int unsigned TAG_CYCLES   = 8
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic [KEY_W-1:0]   key,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    input  logic [3:0]         in_bytes_minus_one,
    input  logic               in_last,
    output logic               tag_valid,
    input  logic               tag_ready,
    output logic [TAG_W-1:0]   tag,
    output logic               err,
    output logic               enc_clear,
    output logic               enc_start,
    output logic [KEY_W-1:0]   enc_key,
    output logic [BLOCK_W-1:0] enc_round_input,
    output logic [3:0]         enc_bytes_minus_one,
    input  logic [TAG_W-1:0]   enc_tag
);

    localparam int unsigned CNT_W = $clog2(max_u(BLOCK_CYCLES, TAG_CYCLES));
    localparam logic [CNT_W-1:0] BLOCK_LOAD = CNT_W'(BLOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] TAG_LOAD   = CNT_W'(TAG_CYCLES - 1);

    seq_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             clr_pulse_q;

    // The encoder is cleared both by the global reset and once per new key.
    assign enc_clear = clear | clr_pulse_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q             <= StIdle;
            cnt_q               <= '0;
            clr_pulse_q         <= 1'b0;
            key_ready           <= 1'b0;
            in_ready            <= 1'b0;
            tag_valid           <= 1'b0;
            tag                 <= '0;
            err                 <= 1'b0;
            enc_start           <= 1'b0;
            enc_key             <= '0;
            enc_round_input     <= '0;
            enc_bytes_minus_one <= '0;
        end else begin
            enc_start   <= 1'b0;
            clr_pulse_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (key_valid && key_ready) begin
                        enc_key     <= key;
                        clr_pulse_q <= 1'b1;
                        key_ready   <= 1'b0;
                        in_ready    <= 1'b1;
                        state_q     <= StAccept;
                    end else begin
                        key_ready <= 1'b1;
                    end
                end
                StAccept: begin
                    if (in_valid && in_ready) begin
                        enc_round_input     <= in_data;
                        enc_bytes_minus_one <= in_bytes_minus_one;
                        enc_start           <= 1'b1;
                        in_ready            <= 1'b0;
                        // A short block is still forwarded; only the flag records it.
                        if (!in_last && (in_bytes_minus_one != FULL_BLOCK_BYTES_MINUS_ONE)) begin
                            err <= 1'b1;
                        end
                        if (in_last) begin
                            cnt_q   <= TAG_LOAD;
                            state_q <= StFinal;
                        end else begin
                            cnt_q   <= BLOCK_LOAD;
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (cnt_q == '0) begin
                        in_ready <= 1'b1;
                        state_q  <= StAccept;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StFinal: begin
                    if (cnt_q == '0) begin
                        tag       <= enc_tag;
                        tag_valid <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                StDone: begin
                    if (tag_ready) begin
                        tag_valid <= 1'b0;
                        key_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
